// File: rtl/rv32_instr_encoder.sv
// rv32_instr_encoder: builds RV32I instruction words from a decoded description.
// Supported formats are R/I/S/B/U/J, plus an `li` pseudo-instruction that expands
// to ADDI, LUI, or LUI+ADDI.
// Output is a registered valid/ready stage. A second LI word waits in a pending
// register until the output stage is free.
// Optional feature: define ENC_RANGE_CHECK_EN to flag out-of-range or misaligned
// immediates on out_err. Without it, immediates are silently truncated.
module rv32_instr_encoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_fmt,
  input  logic [6:0]  in_opcode,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_err
);

  localparam logic [2:0]  FmtR    = 3'd0;
  localparam logic [2:0]  FmtI    = 3'd1;
  localparam logic [2:0]  FmtS    = 3'd2;
  localparam logic [2:0]  FmtB    = 3'd3;
  localparam logic [2:0]  FmtU    = 3'd4;
  localparam logic [2:0]  FmtJ    = 3'd5;
  localparam logic [2:0]  FmtLi   = 3'd6;
  localparam logic [2:0]  FmtRsvd = 3'd7;

  localparam logic [6:0]  OpLui   = 7'h37;
  localparam logic [6:0]  OpOpImm = 7'h13;
  localparam logic [31:0] Nop     = 32'h0000_0013;

  typedef enum logic {StIdle = 1'b0, StEmit2 = 1'b1} state_e;

  state_e      r_state, w_state_nxt;
  logic        r_out_valid, w_out_valid_nxt;
  logic [31:0] r_out_instr, w_out_instr_nxt;
  logic        r_out_err, w_out_err_nxt;
  logic [31:0] r_pend, w_pend_nxt;

  logic [31:0] w_word_r, w_word_i, w_word_s, w_word_b, w_word_u, w_word_j;
  logic [19:0] w_li_hi;
  logic        w_li_small;
  logic        w_li_two;
  logic [31:0] w_li_first;
  logic [31:0] w_li_second;
  logic [31:0] w_word;
  logic        w_err;
  logic        w_range_err;
  logic        w_out_free;
  logic        w_accept;

  assign w_out_free = !r_out_valid || out_ready;
  // Reset gates in_ready so nothing is accepted while rst is held low.
  assign in_ready   = rst && (r_state == StIdle) && w_out_free;
  assign w_accept   = in_valid && in_ready;

  assign out_valid  = r_out_valid;
  assign out_instr  = r_out_instr;
  assign out_err    = r_out_err;

  // Scatter register, funct and immediate fields into each RV32I format.
  always_comb begin
    w_word_r = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
    w_word_i = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
    w_word_s = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
    w_word_b = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                in_imm[4:1], in_imm[11], in_opcode};
    w_word_u = {in_imm[31:12], in_rd, in_opcode};
    w_word_j = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
  end

  // LI expansion. (imm + 0x800) >> 12 equals imm[31:12] + imm[11], so the
  // upper part is computed without a full 32-bit adder.
  always_comb begin
    w_li_small  = (in_imm[31:11] == {21{in_imm[31]}});
    w_li_hi     = in_imm[31:12] + {19'd0, in_imm[11]};
    w_li_two    = !w_li_small && (in_imm[11:0] != 12'd0);
    w_li_second = {in_imm[11:0], in_rd, 3'b000, in_rd, OpOpImm};
    if (w_li_small) begin
      w_li_first = {in_imm[11:0], 5'd0, 3'b000, in_rd, OpOpImm};
    end else begin
      w_li_first = {w_li_hi, in_rd, OpLui};
    end
  end

`ifdef ENC_RANGE_CHECK_EN
  // Range checks. The word is still encoded from the truncated bits.
  logic w_fits12, w_fits13, w_fits21;
  always_comb begin
    w_fits12    = (in_imm[31:11] == {21{in_imm[31]}});
    w_fits13    = (in_imm[31:12] == {20{in_imm[31]}});
    w_fits21    = (in_imm[31:20] == {12{in_imm[31]}});
    w_range_err = 1'b0;
    case (in_fmt)
      FmtI, FmtS: w_range_err = !w_fits12;
      FmtB:       w_range_err = !w_fits13 || in_imm[0];
      FmtJ:       w_range_err = !w_fits21 || in_imm[0];
      FmtU:       w_range_err = (in_imm[11:0] != 12'd0);
      default:    w_range_err = 1'b0;
    endcase
  end
`else
  assign w_range_err = 1'b0;
`endif

  // Select the first output word and its error flag by format.
  always_comb begin
    w_word = Nop;
    w_err  = 1'b0;
    case (in_fmt)
      FmtR:    w_word = w_word_r;
      FmtI:    w_word = w_word_i;
      FmtS:    w_word = w_word_s;
      FmtB:    w_word = w_word_b;
      FmtU:    w_word = w_word_u;
      FmtJ:    w_word = w_word_j;
      FmtLi:   w_word = w_li_first;
      FmtRsvd: begin
        w_word = Nop;
        w_err  = 1'b1;
      end
      default: w_word = Nop;
    endcase
    if (in_fmt != FmtRsvd) begin
      w_err = w_range_err;
    end
  end

  // Next-state logic for the FSM, the output stage and the pending ADDI.
  always_comb begin
    w_state_nxt     = r_state;
    w_out_valid_nxt = r_out_valid;
    w_out_instr_nxt = r_out_instr;
    w_out_err_nxt   = r_out_err;
    w_pend_nxt      = r_pend;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_out_valid_nxt = 1'b1;
          w_out_instr_nxt = w_word;
          w_out_err_nxt   = w_err;
          if ((in_fmt == FmtLi) && w_li_two) begin
            w_pend_nxt  = w_li_second;
            w_state_nxt = StEmit2;
          end
        end else if (w_out_free) begin
          w_out_valid_nxt = 1'b0;
        end
      end
      StEmit2: begin
        if (w_out_free) begin
          w_out_valid_nxt = 1'b1;
          w_out_instr_nxt = r_pend;
          w_out_err_nxt   = 1'b0;
          w_pend_nxt      = 32'd0;
          w_state_nxt     = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  // State and output registers; reset discards any in-flight or pending word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= StIdle;
      r_out_valid <= 1'b0;
      r_out_instr <= Nop;
      r_out_err   <= 1'b0;
      r_pend      <= 32'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_instr <= w_out_instr_nxt;
      r_out_err   <= w_out_err_nxt;
      r_pend      <= w_pend_nxt;
    end
  end

endmodule

// File: tb/tb_rv32_instr_encoder.sv
// Self-checking bench for rv32_instr_encoder: directed cases plus random requests
// compared against a field-arithmetic reference model.
module tb_rv32_instr_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_fmt;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;

  int n_checks = 0;
  int n_fail   = 0;

  rv32_instr_encoder dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_fmt    (in_fmt),
    .in_opcode (in_opcode),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_funct3 (in_funct3),
    .in_funct7 (in_funct7),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---- reference model ----
  function automatic logic [31:0] bits(input logic [31:0] v, input int hi, input int lo);
    logic [31:0] m;
    m = (hi - lo == 31) ? 32'hFFFF_FFFF : ((32'd1 << (hi - lo + 1)) - 32'd1);
    return (v >> lo) & m;
  endfunction

  function automatic logic [31:0] at(input logic [31:0] v, input int pos);
    return v << pos;
  endfunction

  function automatic bit in_rng(input logic [31:0] imm, input int lo, input int hi);
    int s;
    s = $signed(imm);
    return (s >= lo) && (s <= hi);
  endfunction

  // Returns number of expected words (1 or 2) and fills w0/w1/e0.
  function automatic int model(input logic [2:0] fmt, input logic [6:0] op,
                               input logic [4:0] rd, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic [2:0] f3,
                               input logic [6:0] f7, input logic [31:0] imm,
                               output logic [31:0] w0, output logic [31:0] w1,
                               output logic e0);
    logic [31:0] base, hi;
    bit viol;
    base = at(32'(f3), 12) | 32'(op);
    w1   = 32'd0;
    viol = 1'b0;
    e0   = 1'b0;
    case (fmt)
      3'd0: w0 = at(32'(f7), 25) | at(32'(rs2), 20) | at(32'(rs1), 15) | base | at(32'(rd), 7);
      3'd1: begin
        w0 = at(bits(imm, 11, 0), 20) | at(32'(rs1), 15) | base | at(32'(rd), 7);
        viol = !in_rng(imm, -2048, 2047);
      end
      3'd2: begin
        w0 = at(bits(imm, 11, 5), 25) | at(32'(rs2), 20) | at(32'(rs1), 15) | base
             | at(bits(imm, 4, 0), 7);
        viol = !in_rng(imm, -2048, 2047);
      end
      3'd3: begin
        w0 = at(bits(imm, 12, 12), 31) | at(bits(imm, 10, 5), 25) | at(32'(rs2), 20)
             | at(32'(rs1), 15) | base | at(bits(imm, 4, 1), 8) | at(bits(imm, 11, 11), 7);
        viol = !in_rng(imm, -4096, 4094) || imm[0];
      end
      3'd4: begin
        w0 = at(bits(imm, 31, 12), 12) | at(32'(rd), 7) | 32'(op);
        viol = (bits(imm, 11, 0) != 0);
      end
      3'd5: begin
        w0 = at(bits(imm, 20, 20), 31) | at(bits(imm, 10, 1), 21) | at(bits(imm, 11, 11), 20)
             | at(bits(imm, 19, 12), 12) | at(32'(rd), 7) | 32'(op);
        viol = !in_rng(imm, -1048576, 1048574) || imm[0];
      end
      3'd6: begin
        if (in_rng(imm, -2048, 2047)) begin
          w0 = at(bits(imm, 11, 0), 20) | at(32'(rd), 7) | 32'h13;
          return 1;
        end
        hi = (imm + 32'h800) >> 12;
        w0 = at(hi, 12) | at(32'(rd), 7) | 32'h37;
        if (bits(imm, 11, 0) == 0) return 1;
        w1 = at(bits(imm, 11, 0), 20) | at(32'(rd), 15) | at(32'(rd), 7) | 32'h13;
        return 2;
      end
      default: begin
        w0 = 32'h13;
        e0 = 1'b1;
        return 1;
      end
    endcase
`ifdef ENC_RANGE_CHECK_EN
    e0 = viol;
`else
    e0 = 1'b0;
`endif
    return 1;
  endfunction

  // ---- transaction helper: send one request, collect and check its word(s) ----
  task automatic run_req(input string tag, input logic [2:0] fmt, input logic [6:0] op,
                         input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm,
                         input int max_stall);
    logic [31:0] w0, w1, exp_w;
    logic e0, exp_e;
    int nw, stall, waited;
    nw = model(fmt, op, rd, rs1, rs2, f3, f7, imm, w0, w1, e0);
    waited = 0;
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk({tag, "/in_ready_wait"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_fmt = fmt; in_opcode = op; in_rd = rd; in_rs1 = rs1;
    in_rs2 = rs2; in_funct3 = f3; in_funct7 = f7; in_imm = imm;
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int k = 0; k < nw; k++) begin
      exp_w = (k == 0) ? w0 : w1;
      exp_e = (k == 0) ? e0 : 1'b0;
      @(negedge clk);
      chk({tag, "/valid"}, 32'(out_valid), 32'd1);
      chk({tag, "/instr"}, out_instr, exp_w);
      chk({tag, "/err"}, 32'(out_err), 32'(exp_e));
      stall = $urandom_range(0, max_stall);
      for (int s = 0; s < stall; s++) begin
        @(negedge clk);
        chk({tag, "/hold_instr"}, out_instr, exp_w);
        chk({tag, "/hold_err"}, 32'(out_err), 32'(exp_e));
        chk({tag, "/stall_in_ready"}, 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
    end
    @(negedge clk);
    chk({tag, "/drained"}, 32'(out_valid), 32'd0);
    chk({tag, "/idle_ready"}, 32'(in_ready), 32'd1);
  endtask

  logic [31:0] r_imm;
  logic [2:0]  r_fmt;

  initial begin
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_fmt = 3'd0; in_opcode = 7'd0; in_rd = 5'd0; in_rs1 = 5'd0; in_rs2 = 5'd0;
    in_funct3 = 3'd0; in_funct7 = 7'd0; in_imm = 32'd0;

    // Reset state
    #12;
    chk("rst/valid", 32'(out_valid), 32'd0);
    chk("rst/instr", out_instr, 32'h0000_0013);
    chk("rst/err", 32'(out_err), 32'd0);
    chk("rst/in_ready_low", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst/in_ready_after", 32'(in_ready), 32'd1);

    // Directed cases from the plan, with constants computed by hand
    run_req("addi", 3'd1, 7'h13, 5'd5, 5'd6, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 1);
    chk("addi/const", dut.out_instr, 32'hFFF3_0293);
    run_req("beq", 3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8, 1);
    chk("beq/const", out_instr, 32'h0020_8463);
    run_req("li2", 3'd6, 7'h00, 5'd10, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5FFF, 2);
    chk("li2/const", out_instr, 32'hFFF5_0513);
    run_req("li1", 3'd6, 7'h00, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd100, 0);
    chk("li1/const", out_instr, 32'h0640_0093);
    run_req("li_lo0", 3'd6, 7'h00, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 0);
    chk("li_lo0/const", out_instr, 32'h1234_50B7);
    run_req("bmis", 3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3, 0);
    chk("bmis/const", out_instr, 32'h0020_8163);
    run_req("rsvd", 3'd7, 7'h33, 5'd3, 5'd4, 5'd5, 3'd1, 7'd1, 32'd0, 0);
    chk("rsvd/err", 32'(out_err), 32'd1);
    run_req("ubad", 3'd4, 7'h37, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'hABCD_E123, 0);
    run_req("jmax", 3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1048574, 0);
    run_req("jover", 3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1048576, 0);
    run_req("bmin", 3'd3, 7'h63, 5'd0, 5'd3, 5'd4, 3'd1, 7'd0, 32'hFFFF_F000, 0);
    run_req("s_over", 3'd2, 7'h23, 5'd0, 5'd8, 5'd9, 3'd2, 7'd0, 32'd2048, 0);

    // Back-to-back: consume and accept on the same edge, no bubble
    @(negedge clk);
    out_ready = 1'b1;
    in_valid = 1'b1; in_fmt = 3'd1; in_opcode = 7'h13; in_rd = 5'd2; in_rs1 = 5'd0;
    in_funct3 = 3'd0; in_imm = 32'd1;
    @(posedge clk);
    #1 in_imm = 32'd2;
    @(negedge clk);
    chk("b2b/first", out_instr, 32'h0010_0113);
    chk("b2b/in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("b2b/second", out_instr, 32'h0020_0113);
    chk("b2b/valid", 32'(out_valid), 32'd1);
    @(negedge clk);
    chk("b2b/drained", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    // Reset while the ADDI of a two-word LI is pending
    in_valid = 1'b1; in_fmt = 3'd6; in_rd = 5'd10; in_imm = 32'h1234_5FFF;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("rmid/lui", out_instr, 32'h1234_6537);
    chk("rmid/emit2_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("rmid/valid_now", 32'(out_valid), 32'd0);
    chk("rmid/ready_in_rst", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("rmid/ready_after", 32'(in_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rmid/no_pending", 32'(out_valid), 32'd0);
    end
    out_ready = 1'b0;

    // Randomized requests against the model
    for (int i = 0; i < 60; i++) begin
      r_fmt = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0: r_imm = $urandom;
        1: r_imm = 32'($signed($urandom_range(0, 6000)) - 3000);
        2: r_imm = 32'($signed($urandom_range(0, 10000)) - 5000) & 32'hFFFF_FFFE;
        default: r_imm = $urandom & 32'hFFFF_F000;
      endcase
      run_req("rand", r_fmt, 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
              3'($urandom), 7'($urandom), r_imm, 2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rv32_instr_encoder.md
# rv32_instr_encoder

Instruction encoder: the inverse of the immediate generator. Accepts a decoded instruction description (format, opcode, register fields, funct fields, full 32-bit immediate) over a valid/ready handshake. Scatters the immediate into the RV32I bit positions and emits a 32-bit instruction word on a registered valid/ready output. Sits in the test/boot path, producing instruction-memory contents for the single-cycle core, and includes a two-word `li` pseudo-instruction expander.

## Interface
Parameters: none.

Ports (`name  direction  width  meaning`):
- `clk  in  1`  system clock; all state updates on its rising edge.
- `rst  in  1`  **asynchronous, active-low** reset.
- `in_valid  in  1`  request valid.
- `in_ready  out  1`  encoder can accept a request this cycle.
- `in_fmt  in  3`  format select: 0 = R, 1 = I, 2 = S, 3 = B, 4 = U, 5 = J, 6 = LI, 7 = reserved.
- `in_opcode  in  7`  opcode field; ignored for LI.
- `in_rd  in  5`, `in_rs1  in  5`, `in_rs2  in  5`  register fields.
- `in_funct3  in  3`, `in_funct7  in  7`  funct fields.
- `in_imm  in  32`  full signed immediate value, not pre-shifted.
- `out_valid  out  1`  `out_instr` holds a word.
- `out_ready  in  1`  consumer accepts the word.
- `out_instr  out  32`  encoded instruction word.
- `out_err  out  1`  the word was produced from an out-of-range, misaligned or reserved request.

## Operation
- **Handshake.**
  - A request is accepted when `in_valid && in_ready`.
  - A word is consumed when `out_valid && out_ready`.
  - `in_ready = (state == IDLE) && (!out_valid || out_ready)`; it is 0 while `rst` is low.
- **Field placement** (register fields go in the standard positions):
  - R: `{funct7, rs2, rs1, funct3, rd, opcode}`.
  - I: `{imm[11:0], rs1, funct3, rd, opcode}`.
  - S: `{imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}`.
  - B: `{imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}`.
  - U: `{imm[31:12], rd, opcode}`.
  - J: `{imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}`.
- **Range rules:**
  - I and S: imm in [-2048, 2047].
  - B: imm in [-4096, 4094] and imm[0] = 0.
  - J: imm in [-1048576, 1048574] and imm[0] = 0.
  - U: imm[11:0] = 0.
  - R and LI: always in range.
- **Reserved format (`in_fmt` = 7):** emits NOP `32'h00000013` with `out_err` = 1, regardless of the configuration macro.
- **LI expansion** (target register `rd`; `in_opcode`, `in_rs1`, `in_rs2` and funct fields ignored):
  - If imm is in [-2048, 2047]: one word, `ADDI rd, x0, imm`.
  - Otherwise compute `hi = (imm + 0x800) >> 12` (32-bit wrap) and `lo = imm[11:0]`.
  - Emit `LUI rd, hi`.
  - If `lo != 0`, then emit `ADDI rd, rd, lo` as a second word.
- **FSM states:**
  - IDLE to IDLE: accepted non-LI request, or single-word LI.
  - IDLE to EMIT2: accepted two-word LI. The LUI word loads the output register and the ADDI word is held in a pending register.
  - EMIT2 to IDLE: when the output register is free (`!out_valid || out_ready`), the pending ADDI loads into it with `out_err` = 0.

## Timing
- **Reset values:** `out_valid` = 0, `out_instr` = `32'h00000013`, `out_err` = 0, state = IDLE, pending register cleared.
- **Latency:** 1 cycle from acceptance to `out_valid`. Throughput is one word per cycle when `out_ready` is held high.
- **LI two-word timing:** the LUI word appears 1 cycle after acceptance and the ADDI word 1 cycle after the LUI is consumed. `in_ready` stays 0 in EMIT2.
- **Output stability:** `out_instr` and `out_err` hold stable while `out_valid && !out_ready`.
- **Simultaneous consume and accept:** the new word replaces the old word in the same edge, with no bubble.
- **Reset mid-operation:** a word in flight and any pending ADDI are discarded; neither appears after reset release.

## Configuration
- **`ENC_RANGE_CHECK_EN` defined:**
  - The range rules are evaluated.
  - `out_err` = 1 on any violation.
  - The word is still encoded from the truncated immediate bits.
- **Not defined:**
  - No range logic is compiled.
  - `out_err` is driven only by the reserved-format case.
  - Immediates are silently truncated; B/J imm[0] is dropped.

## Test plan
- **I-type ADDI:** fmt 1, opcode 0x13, rd 5, rs1 6, funct3 0, imm 0xFFFFFFFF -> `out_instr` = 0xFFF30293 one cycle later, `out_err` = 0.
- **B-type BEQ:** fmt 3, opcode 0x63, rs1 1, rs2 2, funct3 0, imm 8 -> 0x00208463.
- **Two-word LI:** LI rd 10, imm 0x12345FFF, `out_ready` low for 1 cycle after the first word.
  - Words are 0x12346537 then 0xFFF50513.
  - `in_ready` = 0 until the ADDI is loaded.
- **Single-word LI:** LI rd 1, imm 100 -> single word 0x06400093.
- **LI with zero low part:** LI rd 1, imm 0x12345000 -> single LUI word only.
- **Misaligned B immediate:** B imm 3.
  - With `ENC_RANGE_CHECK_EN`: `out_err` = 1 and word 0x00208163 (rs1 1, rs2 2).
  - Without the macro: `out_err` = 0 and the same word.
- **Reset mid-LI:** assert `rst` in EMIT2 -> `out_valid` = 0 immediately, and `in_ready` = 1 on the first cycle after release. The pending ADDI is never emitted.
